// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, decode
// constants and the rstatus exception codes used by the main control decoder.
package md_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } md_state_e;

    localparam logic [4:0] OP_RTYPE    = 5'b00000;
    localparam logic [4:0] ALU_MUL     = 5'b00110;
    localparam logic [4:0] ALU_DIV     = 5'b00111;
    localparam logic [4:0] REG_RSTATUS = 5'b11110;

    localparam logic [31:0] EXC_MUL     = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;
    localparam logic [31:0] EXC_TIMEOUT = 32'd6;

    // A timeout outranks the operation-specific code.
    function automatic logic [31:0] exc_code(input logic timeout, input logic is_div);
        if (timeout)
            return EXC_TIMEOUT;
        else if (is_div)
            return EXC_DIV;
        else
            return EXC_MUL;
    endfunction

endpackage

// File: rtl/md_timeout_cnt.sv
// WAIT-cycle counter for the md sequencer: clearable, enabled up-counter
// flagging the last allowed cycle before a forced timeout.
module md_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/md_seq_ctrl.sv
// Multi-cycle sequencer that stalls the CPU around a mul/div and writes back the
// result (or an rstatus code). Define MD_STALL_PERF_EN for stall/timeout counters.
module md_seq_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opcode,
    input  logic [4:0]  ALUopcode,
    input  logic [4:0]  Rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        md_wb_en,
    output logic [4:0]  md_wb_reg,
    output logic [31:0] md_wb_data,
    output logic        busy
`ifdef MD_STALL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] md_timeouts
`endif
);

    md_state_e   state, next_state;
    logic        is_mul, is_div, is_md;
    logic        op_is_div;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic        exc_q, timeout_q;
    logic        cnt_clear, cnt_en, cnt_tc;

    assign is_mul = (opcode == OP_RTYPE) && (ALUopcode == ALU_MUL);
    assign is_div = (opcode == OP_RTYPE) && (ALUopcode == ALU_DIV);
    assign is_md  = is_mul | is_div;

    md_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Everything except the IDLE stall is decoded from state and latched regs.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;
        stall      = 1'b0;
        md_wb_en   = 1'b0;
        md_wb_reg  = 5'd0;
        md_wb_data = 32'd0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                stall = is_md;
                if (is_md)
                    next_state = ST_START;
            end
            ST_START: begin
                ctrl_MULT  = ~op_is_div;
                ctrl_DIV   = op_is_div;
                stall      = 1'b1;
                cnt_clear  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                if (md_ready || cnt_tc)
                    next_state = ST_WB;
            end
            ST_WB: begin
                md_wb_en   = exc_q | (rd_q != 5'd0);
                md_wb_reg  = exc_q ? REG_RSTATUS : rd_q;
                md_wb_data = exc_q ? exc_code(timeout_q, op_is_div) : result_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (reset)
            stall = 1'b0;
    end

    // A result arriving on the timeout cycle wins over the timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_is_div <= 1'b0;
            rd_q      <= 5'd0;
            result_q  <= 32'd0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_md) begin
                        op_is_div <= is_div;
                        rd_q      <= Rd;
                    end
                end
                ST_WAIT: begin
                    if (md_ready) begin
                        result_q  <= md_result;
                        exc_q     <= md_exception;
                        timeout_q <= 1'b0;
                    end else if (cnt_tc) begin
                        exc_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MD_STALL_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            md_timeouts  <= 16'd0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if ((state == ST_WB) && timeout_q && (md_timeouts != 16'hFFFF))
                md_timeouts <= md_timeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Randomized self-checking bench for md_seq_ctrl; expectations come from a
// transaction-level model of latency, pulses and writeback (MD_STALL_PERF_EN aware).
module tb_md_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  opcode, ALUopcode, Rd;
    logic        md_ready, md_exception;
    logic [31:0] md_result;
    logic        ctrl_MULT, ctrl_DIV, stall, md_wb_en, busy;
    logic [4:0]  md_wb_reg;
    logic [31:0] md_wb_data;
`ifdef MD_STALL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] md_timeouts;
`endif

    int checks = 0;
    int failures = 0;
    int exp_stall_total = 0;
    int exp_timeouts = 0;

    always #5 clock = ~clock;

    md_seq_ctrl #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .ALUopcode    (ALUopcode),
        .Rd           (Rd),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .md_result    (md_result),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .stall        (stall),
        .md_wb_en     (md_wb_en),
        .md_wb_reg    (md_wb_reg),
        .md_wb_data   (md_wb_data),
        .busy         (busy)
`ifdef MD_STALL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .md_timeouts  (md_timeouts)
`endif
    );

    task automatic drive_non_md();
        logic [4:0] op, alu;
        op  = 5'($urandom);
        alu = 5'($urandom);
        if (op == 5'd0 && (alu == 5'd6 || alu == 5'd7))
            alu = 5'd1;
        opcode    = op;
        ALUopcode = alu;
        Rd        = 5'($urandom);
    endtask

    // Idle cycles with non-md instructions; optional spurious md_ready pulses.
    task automatic idle_cycles(input int n, input bit spurious);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset = 1'b0;
            drive_non_md();
            md_ready     = spurious ? 1'($urandom) : 1'b0;
            md_exception = 1'($urandom);
            md_result    = $urandom;
            #1;
            checks++;
            if (busy !== 1'b0 || stall !== 1'b0 || md_wb_en !== 1'b0 ||
                ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_quiet: busy=%b stall=%b wb_en=%b mult=%b div=%b required all 0",
                         busy, stall, md_wb_en, ctrl_MULT, ctrl_DIV);
            end
        end
    endtask

    // One md instruction; n_wait = WAIT cycle carrying md_ready (0 = never).
    task automatic run_md(input bit is_div, input logic [4:0] rd, input int n_wait,
                          input bit exc, input logic [31:0] result);
        bit          exp_to, exp_wr, done, pulse_bad;
        int          exp_wait, k, mult_cnt, div_cnt, stall_cnt, wr_cnt;
        logic [4:0]  exp_reg, wr_reg;
        logic [31:0] exp_data, wr_data;

        exp_to   = (n_wait == 0 || n_wait > 40);
        exp_wait = exp_to ? 40 : n_wait;
        exp_wr   = 1'b1;
        if (exp_to) begin
            exp_reg = 5'd30; exp_data = 32'd6;
        end else if (exc) begin
            exp_reg = 5'd30; exp_data = is_div ? 32'd5 : 32'd4;
        end else begin
            exp_reg = rd; exp_data = result;
            exp_wr  = (rd != 5'd0);
        end

        k = 0; done = 0; pulse_bad = 0;
        mult_cnt = 0; div_cnt = 0; stall_cnt = 0; wr_cnt = 0;
        wr_reg = 5'd0; wr_data = 32'd0;
        while (!done && k < 80) begin
            @(negedge clock);
            reset     = 1'b0;
            opcode    = 5'd0;
            ALUopcode = is_div ? 5'd7 : 5'd6;
            Rd        = (k == 0) ? rd : 5'($urandom);
            if (n_wait != 0 && k == n_wait + 1)
                md_ready = 1'b1;
            else if (k <= 1)
                md_ready = 1'($urandom);
            else
                md_ready = 1'b0;
            md_exception = md_ready ? exc : 1'($urandom);
            md_result    = md_ready ? result : $urandom;
            #1;
            if (ctrl_MULT === 1'b1) begin mult_cnt++; if (k != 1) pulse_bad = 1; end
            if (ctrl_DIV === 1'b1) begin div_cnt++; if (k != 1) pulse_bad = 1; end
            if (stall === 1'b1) stall_cnt++;
            if (md_wb_en === 1'b1) begin wr_cnt++; wr_reg = md_wb_reg; wr_data = md_wb_data; end
            if (k > 0 && busy === 1'b1 && stall === 1'b0) done = 1;
            k++;
        end

        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL md_no_writeback: no WB within %0d cycles", k);
        end
        checks++;
        if (mult_cnt != (is_div ? 0 : 1) || div_cnt != (is_div ? 1 : 0) || pulse_bad) begin
            failures++;
            $display("[TB] FAIL start_pulse: mult=%0d div=%0d misplaced=%0d required mult=%0d div=%0d in START",
                     mult_cnt, div_cnt, pulse_bad, is_div ? 0 : 1, is_div ? 1 : 0);
        end
        checks++;
        if (stall_cnt != exp_wait + 2) begin
            failures++;
            $display("[TB] FAIL stall_cycles_seen: got %0d required %0d", stall_cnt, exp_wait + 2);
        end
        checks++;
        if (k != exp_wait + 3) begin
            failures++;
            $display("[TB] FAIL total_latency: got %0d required %0d", k, exp_wait + 3);
        end
        checks++;
        if (wr_cnt != (exp_wr ? 1 : 0)) begin
            failures++;
            $display("[TB] FAIL write_count: got %0d required %0d", wr_cnt, exp_wr ? 1 : 0);
        end
        if (exp_wr && wr_cnt == 1) begin
            checks++;
            if (wr_reg !== exp_reg || wr_data !== exp_data) begin
                failures++;
                $display("[TB] FAIL writeback: got r%0d=0x%08h required r%0d=0x%08h",
                         wr_reg, wr_data, exp_reg, exp_data);
            end
        end
        exp_stall_total += exp_wait + 2;
        if (exp_to) exp_timeouts++;
    endtask

    task automatic check_perf();
`ifdef MD_STALL_PERF_EN
        checks++;
        if (stall_cycles !== 32'(exp_stall_total)) begin
            failures++;
            $display("[TB] FAIL perf_stall_cycles: got %0d required %0d", stall_cycles, exp_stall_total);
        end
        checks++;
        if (md_timeouts !== 16'(exp_timeouts)) begin
            failures++;
            $display("[TB] FAIL perf_md_timeouts: got %0d required %0d", md_timeouts, exp_timeouts);
        end
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            reset = 1'b1; opcode = 5'd0; ALUopcode = 5'd6; Rd = 5'd3;
            md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
            #1;
            if (i > 0) begin
                checks++;
                if (stall !== 1'b0 || busy !== 1'b0 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL reset_ctrl: stall=%b busy=%b mult=%b div=%b required 0",
                             stall, busy, ctrl_MULT, ctrl_DIV);
                end
                checks++;
                if (md_wb_en !== 1'b0 || md_wb_reg !== 5'd0 || md_wb_data !== 32'd0) begin
                    failures++;
                    $display("[TB] FAIL reset_wb: en=%b reg=%0d data=0x%08h required 0",
                             md_wb_en, md_wb_reg, md_wb_data);
                end
            end
        end
        exp_stall_total = 0; exp_timeouts = 0;
        idle_cycles(2, 1'b0);
        check_perf();
    endtask

    task automatic test_directed();
        run_md(1'b0, 5'd3, 32, 1'b0, 32'h0000_002A);
        idle_cycles(1, 1'b0);
        run_md(1'b1, 5'd5, 12, 1'b1, 32'hDEAD_BEEF);
        idle_cycles(1, 1'b0);
        run_md(1'b0, 5'd7, 0, 1'b0, 32'h1234_5678);
        idle_cycles(1, 1'b0);
        check_perf();
        run_md(1'b1, 5'd9, 40, 1'b0, 32'hCAFE_0001);
        idle_cycles(1, 1'b0);
        run_md(1'b0, 5'd0, 5, 1'b0, 32'h0000_0077);
        idle_cycles(1, 1'b0);
        run_md(1'b0, 5'd0, 5, 1'b1, 32'h0000_0077);
        idle_cycles(1, 1'b0);
        check_perf();
    endtask

    task automatic test_reset_mid_wait();
        int stall_cnt, wr_cnt;
        stall_cnt = 0; wr_cnt = 0;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clock);
            reset = (k == 11); opcode = 5'd0; ALUopcode = 5'd6; Rd = 5'd9;
            md_ready = 1'b0; md_exception = 1'b0; md_result = $urandom;
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (md_wb_en === 1'b1) wr_cnt++;
        end
        checks++;
        if (stall_cnt != 11 || wr_cnt != 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait_pre: stalls=%0d writes=%0d required 11 and 0", stall_cnt, wr_cnt);
        end
        exp_stall_total = 0; exp_timeouts = 0;
        idle_cycles(6, 1'b1);
        check_perf();
    endtask

    task automatic test_back_to_back();
        run_md(1'b0, 5'd1, int'($urandom_range(1, 10)), 1'b0, $urandom);
        run_md(1'b1, 5'd2, int'($urandom_range(1, 10)), 1'b0, $urandom);
        idle_cycles(1, 1'b0);
        check_perf();
    endtask

    task automatic test_random();
        int nw;
        for (int i = 0; i < 14; i++) begin
            nw = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 45));
            run_md(1'($urandom), 5'($urandom), nw, ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 2) != 0) begin
                idle_cycles(int'($urandom_range(1, 3)), 1'b1);
                check_perf();
            end
        end
        idle_cycles(1, 1'b0);
        check_perf();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
